prefetch_fetcher: RTL and testbench

Parametrised instruction fetcher for a MiniGPU core.
- Runs ahead of the core: issues sequential reads over the valid/ready memory port and buffers responses, with their PCs, in a DEPTH-entry prefetch queue.
- The core takes instructions through a valid/ready consumer port.
- A redirect input (branch/jump/kernel start) flushes the queue and restarts fetch at a new PC, discarding any response still in flight.

---
 rtl/fetcher_pkg.sv | 10 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/prefetch_fetcher.sv | 138 +++++++++++++
 tb/tb_prefetch_fetcher.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetcher_pkg.sv
// Shared definitions for the prefetch fetcher: FSM state encodings.
package fetcher_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        DISCARD = 2'b10
    } fetcher_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries with flush; the head word is read
// directly from the storage registers.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    assign pop_ok = pop & (count != '0);

    // Storage is cleared on reset so the head never shows X while empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/prefetch_fetcher.sv
// Prefetching instruction fetcher: runs sequential reads ahead of the core into a
// small queue; a redirect flushes the queue and restarts fetch at a new PC.
module prefetch_fetcher
    import fetcher_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 4,
    parameter int PC_STEP     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_enable,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   mem_read_valid,
    output logic [ADDR_WIDTH-1:0]  mem_read_address,
    input  logic                   mem_read_ready,
    input  logic [INSTR_WIDTH-1:0] mem_read_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic [1:0]             fetcher_state,
    output logic [$clog2(DEPTH):0] queue_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_WIDTH + INSTR_WIDTH;

    fetcher_state_t        state;
    fetcher_state_t        state_n;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] fetch_pc_n;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  valid_n;
    logic                  push;
    logic                  pop;
    logic                  can_issue;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic [ENT_W-1:0]      head;

    assign pop        = instr_valid & instr_ready;
    assign push       = (state == REQ) & mem_read_ready & ~redirect_valid;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign can_issue  = fetch_enable & ~redirect_valid & (count_next < CNT_W'(DEPTH));
    assign pc_inc     = fetch_pc + ADDR_WIDTH'(PC_STEP);

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        addr_n     = mem_read_address;
        valid_n    = mem_read_valid;
        if (redirect_valid) begin
            fetch_pc_n = redirect_pc;
        end
        case (state)
            IDLE: begin
                if (can_issue) begin
                    state_n = REQ;
                    valid_n = 1'b1;
                    addr_n  = fetch_pc;
                end
            end
            REQ: begin
                // A redirect with no response yet must still let the old read finish.
                if (redirect_valid) begin
                    if (mem_read_ready) begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end else begin
                        state_n = DISCARD;
                    end
                end else if (mem_read_ready) begin
                    fetch_pc_n = pc_inc;
                    if (can_issue) begin
                        addr_n = pc_inc;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end
            end
            DISCARD: begin
                if (mem_read_ready) begin
                    if (can_issue) begin
                        state_n = REQ;
                        addr_n  = fetch_pc;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            fetch_pc         <= '0;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
        end else begin
            state            <= state_n;
            fetch_pc         <= fetch_pc_n;
            mem_read_valid   <= valid_n;
            mem_read_address <= addr_n;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({fetch_pc, mem_read_data}),
        .rdata (head),
        .count (count)
    );

    assign instr_valid   = (count != '0);
    assign instruction   = head[INSTR_WIDTH-1:0];
    assign instr_pc      = head[ENT_W-1:INSTR_WIDTH];
    assign fetcher_state = state;
    assign queue_count   = count;

endmodule

// File: tb/tb_prefetch_fetcher.sv
// Directed bench for prefetch_fetcher; popped instructions are checked against a
// scoreboard queue filled by the stimulus process.
module tb_prefetch_fetcher;

    localparam int AW    = 8;
    localparam int IW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fetch_enable = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready = 1'b0;
    logic [IW-1:0] mem_read_data;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [IW-1:0] instruction;
    logic [AW-1:0] instr_pc;
    logic [1:0]    fetcher_state;
    logic [2:0]    queue_count;

    logic [AW+IW-1:0] exp_q[$];
    logic [AW+IW-1:0] mon_exp;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Program memory: word at address a is {~a, a}.
    assign mem_read_data = {~mem_read_address, mem_read_address};

    prefetch_fetcher #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .DEPTH       (DEPTH),
        .PC_STEP     (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_enable     (fetch_enable),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instruction      (instruction),
        .instr_pc         (instr_pc),
        .fetcher_state    (fetcher_state),
        .queue_count      (queue_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake on the consumer port must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc 0x%0h instr 0x%0h, want no pop", instr_pc, instruction);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({instr_pc, instruction} !== mon_exp) begin
                    errors++;
                    $display("FAIL pop_data: got pc 0x%0h instr 0x%0h, want pc 0x%0h instr 0x%0h",
                             instr_pc, instruction, mon_exp[AW+IW-1:IW], mon_exp[IW-1:0]);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) step();
        chk("rst_mem_valid", 32'(mem_read_valid), 0);
        chk("rst_mem_addr", 32'(mem_read_address), 0);
        chk("rst_state", 32'(fetcher_state), 0);
        chk("rst_count", 32'(queue_count), 0);
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_instruction", 32'(instruction), 0);
        chk("rst_instr_pc", 32'(instr_pc), 0);
        reset = 1'b1;
        step();
        step();
        chk("idle_no_issue", 32'(mem_read_valid), 0);

        // Sequential fetch from 0x10 until the queue fills
        redirect_valid = 1'b1;
        redirect_pc    = 8'h10;
        fetch_enable   = 1'b1;
        mem_read_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("redir_state_idle", 32'(fetcher_state), 0);
        chk("redir_no_issue", 32'(mem_read_valid), 0);
        exp_q.push_back({8'h10, 16'hEF10});
        exp_q.push_back({8'h11, 16'hEE11});
        exp_q.push_back({8'h12, 16'hED12});
        exp_q.push_back({8'h13, 16'hEC13});
        step();
        for (int i = 0; i < 4; i++) begin
            chk("seq_valid", 32'(mem_read_valid), 1);
            chk("seq_addr", 32'(mem_read_address), 32'h10 + i);
            step();
        end
        chk("full_valid", 32'(mem_read_valid), 0);
        chk("full_count", 32'(queue_count), 4);
        step();
        step();
        chk("full_hold_valid", 32'(mem_read_valid), 0);
        chk("full_hold_count", 32'(queue_count), 4);
        fetch_enable = 1'b0;
        instr_ready  = 1'b1;
        repeat (4) step();
        instr_ready = 1'b0;
        chk("drain_count", 32'(queue_count), 0);
        chk("drain_instr_valid", 32'(instr_valid), 0);

        // Memory stalls three cycles on 0x14
        mem_read_ready = 1'b0;
        fetch_enable   = 1'b1;
        step();
        fetch_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(mem_read_valid), 1);
            chk("stall_addr", 32'(mem_read_address), 'h14);
            chk("stall_count", 32'(queue_count), 0);
            step();
        end
        exp_q.push_back({8'h14, 16'hEB14});
        mem_read_ready = 1'b1;
        step();
        chk("accept_count", 32'(queue_count), 1);
        chk("accept_state", 32'(fetcher_state), 0);
        chk("accept_valid", 32'(mem_read_valid), 0);
        step();
        chk("one_push_count", 32'(queue_count), 1);

        // Push and pop in the same cycle
        fetch_enable = 1'b1;
        step();
        chk("pp_addr", 32'(mem_read_address), 'h15);
        fetch_enable = 1'b0;
        instr_ready  = 1'b1;
        exp_q.push_back({8'h15, 16'hEA15});
        step();
        chk("pushpop_count", 32'(queue_count), 1);
        step();
        instr_ready = 1'b0;
        chk("pp_drain_count", 32'(queue_count), 0);

        // Redirect to 0x40 while 0x12 is outstanding
        redirect_valid = 1'b1;
        redirect_pc    = 8'h12;
        mem_read_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        fetch_enable   = 1'b1;
        step();
        chk("d_req_addr", 32'(mem_read_address), 'h12);
        chk("d_req_state", 32'(fetcher_state), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        step();
        redirect_valid = 1'b0;
        chk("discard_state", 32'(fetcher_state), 2);
        chk("discard_valid", 32'(mem_read_valid), 1);
        chk("discard_addr", 32'(mem_read_address), 'h12);
        chk("discard_count", 32'(queue_count), 0);
        step();
        chk("discard_hold", 32'(fetcher_state), 2);
        mem_read_ready = 1'b1;
        step();
        chk("after_discard_state", 32'(fetcher_state), 1);
        chk("after_discard_addr", 32'(mem_read_address), 'h40);
        chk("dropped_count", 32'(queue_count), 0);
        fetch_enable = 1'b0;
        exp_q.push_back({8'h40, 16'hBF40});
        step();
        chk("d_push_count", 32'(queue_count), 1);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;

        // Redirect coinciding with the memory response
        mem_read_ready = 1'b0;
        fetch_enable   = 1'b1;
        step();
        chk("co_req_addr", 32'(mem_read_address), 'h41);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        mem_read_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("co_state", 32'(fetcher_state), 0);
        chk("co_count", 32'(queue_count), 0);
        chk("co_valid", 32'(mem_read_valid), 0);
        step();
        chk("co_next_state", 32'(fetcher_state), 1);
        chk("co_next_addr", 32'(mem_read_address), 'h80);
        fetch_enable = 1'b0;
        exp_q.push_back({8'h80, 16'h7F80});
        step();
        chk("co_push_count", 32'(queue_count), 1);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("sb_drained", 32'(exp_q.size()), 0);

        // PC wrap from 0xFE
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        fetch_enable   = 1'b1;
        mem_read_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        exp_q.push_back({8'hFE, 16'h01FE});
        exp_q.push_back({8'hFF, 16'h00FF});
        exp_q.push_back({8'h00, 16'hFF00});
        step();
        chk("wrap_fe", 32'(mem_read_address), 'hFE);
        step();
        chk("wrap_ff", 32'(mem_read_address), 'hFF);
        step();
        chk("wrap_00", 32'(mem_read_address), 'h00);
        step();
        mem_read_ready = 1'b0;
        chk("wrap_01", 32'(mem_read_address), 'h01);
        chk("wrap_count", 32'(queue_count), 3);
        step();
        chk("prerst_state", 32'(fetcher_state), 1);

        // Asynchronous reset mid-request with a loaded queue
        #2 reset = 1'b0;
        #1;
        chk("arst_mem_valid", 32'(mem_read_valid), 0);
        chk("arst_mem_addr", 32'(mem_read_address), 0);
        chk("arst_state", 32'(fetcher_state), 0);
        chk("arst_count", 32'(queue_count), 0);
        chk("arst_instr_valid", 32'(instr_valid), 0);
        chk("arst_instruction", 32'(instruction), 0);
        chk("arst_instr_pc", 32'(instr_pc), 0);
        exp_q.delete();
        fetch_enable   = 1'b0;
        mem_read_ready = 1'b0;
        step();
        reset = 1'b1;
        repeat (3) step();
        chk("post_rst_valid", 32'(mem_read_valid), 0);
        chk("post_rst_state", 32'(fetcher_state), 0);
        fetch_enable   = 1'b1;
        mem_read_ready = 1'b1;
        step();
        chk("restart_valid", 32'(mem_read_valid), 1);
        chk("restart_addr", 32'(mem_read_address), 'h00);
        fetch_enable = 1'b0;
        exp_q.push_back({8'h00, 16'hFF00});
        step();
        chk("restart_count", 32'(queue_count), 1);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("sb_final_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
